// File: rtl/ex_reg.sv
// EX-stage control pipeline register for the semiMIPS datapath.
// Captures ALU/regdst controls from decode; supports stall (hold) and flush (bubble).
module ex_reg #(
    parameter int                   ALUOP_W   = 3,
    parameter int                   SRC_W     = 2,
    parameter logic [ALUOP_W-1:0]   NOP_ALUOP = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               alualtsrcin,
    input  logic [SRC_W-1:0]   alusrcin,
    input  logic [SRC_W-1:0]   regdstin,
    input  logic [ALUOP_W-1:0] aluopin,
    output logic               alualtsrcout,
    output logic [SRC_W-1:0]   alusrcout,
    output logic [SRC_W-1:0]   regdstout,
    output logic [ALUOP_W-1:0] aluopout
);

    logic               alualtsrc_q, alualtsrc_d;
    logic [SRC_W-1:0]   alusrc_q,    alusrc_d;
    logic [SRC_W-1:0]   regdst_q,    regdst_d;
    logic [ALUOP_W-1:0] aluop_q,     aluop_d;

    // Flush outranks stall so a bubble can be inserted while the stage is held.
    always_comb begin
        alualtsrc_d = alualtsrc_q;
        alusrc_d    = alusrc_q;
        regdst_d    = regdst_q;
        aluop_d     = aluop_q;
        if (flush) begin
            alualtsrc_d = 1'b0;
            alusrc_d    = '0;
            regdst_d    = '0;
            aluop_d     = NOP_ALUOP;
        end else if (!stall) begin
            alualtsrc_d = alualtsrcin;
            alusrc_d    = alusrcin;
            regdst_d    = regdstin;
            aluop_d     = aluopin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alualtsrc_q <= 1'b0;
            alusrc_q    <= '0;
            regdst_q    <= '0;
            aluop_q     <= NOP_ALUOP;
        end else begin
            alualtsrc_q <= alualtsrc_d;
            alusrc_q    <= alusrc_d;
            regdst_q    <= regdst_d;
            aluop_q     <= aluop_d;
        end
    end

    assign alualtsrcout = alualtsrc_q;
    assign alusrcout    = alusrc_q;
    assign regdstout    = regdst_q;
    assign aluopout     = aluop_q;

endmodule

// File: tb/tb_ex_reg.sv
// Self-checking bench for ex_reg: directed scenarios plus randomized traffic
// compared every cycle against a bundle-level behavioural model.
module tb_ex_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       alualtsrcin = 1'b0;
    logic [1:0] alusrcin = '0;
    logic [1:0] regdstin = '0;
    logic [2:0] aluopin = '0;
    logic       alualtsrcout;
    logic [1:0] alusrcout;
    logic [1:0] regdstout;
    logic [2:0] aluopout;

    int checks = 0;
    int failures = 0;

    always #2 clk = ~clk;

    ex_reg #(.ALUOP_W(3), .SRC_W(2), .NOP_ALUOP(3'b000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .alualtsrcin(alualtsrcin), .alusrcin(alusrcin),
        .regdstin(regdstin), .aluopin(aluopin),
        .alualtsrcout(alualtsrcout), .alusrcout(alusrcout),
        .regdstout(regdstout), .aluopout(aluopout)
    );

    // Model: the bundle as one 8-bit word {alt, src, dst, op}; bubble is all zero.
    logic [7:0] model_q;
    bit         model_valid = 0;

    always @(posedge clk) begin
        if (rst || flush) begin
            model_q = 8'h00;
            model_valid = 1;
        end else if (!stall) begin
            model_q = {alualtsrcin, alusrcin, regdstin, aluopin};
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid)
            chk("model_bundle", {alualtsrcout, alusrcout, regdstout, aluopout}, model_q);
    end

    task automatic lit(input string nm, input logic a, input logic [1:0] s,
                       input logic [1:0] r, input logic [2:0] o);
        chk({nm, "_alt"}, {7'd0, alualtsrcout}, {7'd0, a});
        chk({nm, "_src"}, {6'd0, alusrcout},    {6'd0, s});
        chk({nm, "_dst"}, {6'd0, regdstout},    {6'd0, r});
        chk({nm, "_op"},  {5'd0, aluopout},     {5'd0, o});
    endtask

    task automatic drive(input logic a, input logic [1:0] s,
                         input logic [1:0] r, input logic [2:0] o);
        alualtsrcin = a; alusrcin = s; regdstin = r; aluopin = o;
    endtask

    task automatic next_slot();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 2'b11, 2'b11, 3'b111);
        next_slot();
        lit("reset", 1'b0, 2'b00, 2'b00, 3'b000);

        rst = 1'b0;
        drive(1'b0, 2'b10, 2'b11, 3'b011);
        #1;
        lit("pre_edge", 1'b0, 2'b00, 2'b00, 3'b000);
        next_slot();
        lit("pass", 1'b0, 2'b10, 2'b11, 3'b011);

        alusrcin = 2'b11;
        #2;
        chk("midcycle_hold", {6'd0, alusrcout}, 8'h02);
        next_slot();
        chk("midcycle_load", {6'd0, alusrcout}, 8'h03);

        drive(1'b1, 2'b01, 2'b10, 3'b101);
        next_slot();
        lit("stall_load", 1'b1, 2'b01, 2'b10, 3'b101);
        stall = 1'b1;
        drive(1'b0, 2'b10, 2'b01, 3'b010);
        for (int i = 0; i < 3; i++) begin
            next_slot();
            lit("stall_hold", 1'b1, 2'b01, 2'b10, 3'b101);
        end
        stall = 1'b0;
        next_slot();
        lit("stall_release", 1'b0, 2'b10, 2'b01, 3'b010);

        drive(1'b1, 2'b11, 2'b11, 3'b111);
        next_slot();
        lit("flush_pre", 1'b1, 2'b11, 2'b11, 3'b111);
        flush = 1'b1; stall = 1'b1;
        next_slot();
        lit("flush_over_stall", 1'b0, 2'b00, 2'b00, 3'b000);
        rst = 1'b1; stall = 1'b0;
        next_slot();
        lit("rst_flush", 1'b0, 2'b00, 2'b00, 3'b000);
        rst = 1'b0; flush = 1'b0;

        drive(1'b1, 2'b01, 2'b11, 3'b110);
        next_slot();
        lit("pre_rst_stall", 1'b1, 2'b01, 2'b11, 3'b110);
        stall = 1'b1; rst = 1'b1;
        next_slot();
        lit("rst_over_stall", 1'b0, 2'b00, 2'b00, 3'b000);
        stall = 1'b0; rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 2'($urandom), 2'($urandom), 3'($urandom));
            rst   = ($urandom_range(0, 29) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                #1;
                aluopin = 3'($urandom);
                next_slot();
            end else begin
                next_slot();
            end
        end

        rst = 1'b0; flush = 1'b0; stall = 1'b0;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
